mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- AWIDTH, 12, address width.
- DWIDTH, 16, data width.
- WAIT_CYCLES, 1, wait states inserted before each array access (0..7).
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, clock; all state changes on the rising edge.
- i_clr_reg, in, 1, reset; asynchronous, active-high.
- i_ce, in, 1, access request (level) from the datapath.
- i_we, in, 1, 1 = write, 0 = read; sampled with the request.
- i_addr, in, AWIDTH, word address; sampled with the request.
- i_data, in, DWIDTH, write data; sampled with the request.
- i_ld_en, in, 1, program-load write strobe.
- i_ld_addr, in, AWIDTH, program-load address.
- i_ld_data, in, DWIDTH, program-load data.
- o_data, out, DWIDTH, registered read data.
- o_ready, out, 1, one-cycle access-complete pulse.
- o_busy, out, 1, high whenever state is not IDLE.
- o_err, out, 1, sticky protocol-error flag.
REQ-003 The block SHALL be the memory-side responder for the datapath's ce/we/addr/data interface.
REQ-004 Storage SHALL be 2^AWIDTH words of DWIDTH bits.

Function
REQ-005 The FSM SHALL have four states: IDLE, WAIT, ACCESS, DONE.
REQ-006 An internal flag "armed" SHALL be set whenever i_ce is sampled low.
REQ-007 In IDLE, a request SHALL be accepted on an edge where i_ce=1 and armed=1 and i_ld_en=0:
- i_we, i_addr and i_data are captured into internal registers;
- armed is cleared;
- next state is WAIT if WAIT_CYCLES>0, else ACCESS.
REQ-008 A held-high i_ce SHALL NOT produce a second access; i_ce must be sampled low before the next request is accepted.
REQ-009 WAIT SHALL load a counter with WAIT_CYCLES on entry, decrement it each edge, and leave for ACCESS on the edge where the counter equals 1.
REQ-010 On the ACCESS edge:
- captured write: array[addr] <= data, and o_data is unchanged;
- captured read: o_data <= array[addr];
- in both cases o_ready <= 1 and the next state is DONE.
REQ-011 On the DONE edge, o_ready SHALL return to 0 and the next state SHALL be IDLE.
REQ-012 o_ready SHALL be high for exactly one cycle, beginning after edge N+WAIT_CYCLES+1, where N is the accept edge.
REQ-013 o_data SHALL hold the last read value until the next read completes.
REQ-014 o_busy SHALL be 1 from the edge after accept through the DONE cycle inclusive.
REQ-015 i_ce falling during WAIT or ACCESS SHALL NOT abort the access; the access completes and o_err is set to 1 (sticky).
REQ-016 i_addr, i_data and i_we changes after the accept edge SHALL have no effect on the access in flight.
REQ-017 The program-load port SHALL behave as follows:
- in IDLE, i_ld_en=1 writes array[i_ld_addr] <= i_ld_data on the edge;
- in IDLE, i_ld_en has priority over i_ce, so a concurrent request stays pending and is accepted on the first edge with i_ld_en=0;
- outside IDLE, i_ld_en=1 is ignored (array unchanged) and o_err is set to 1.
REQ-018 A read of an address in the same cycle as a load to that address cannot occur, because of REQ-017 priority.
REQ-019 Address wrap-around SHALL NOT apply; every AWIDTH-bit address is valid.

Reset
REQ-020 While i_clr_reg=1, the block SHALL hold:
- state IDLE, o_data=0, o_ready=0, o_busy=0, o_err=0;
- armed=0, wait counter 0, captured registers 0.
REQ-021 Array contents SHALL NOT be cleared by reset.
REQ-022 Reset asserted in WAIT or before the ACCESS edge SHALL abort the access: no array write and no o_ready pulse.
REQ-023 After reset release, i_ce SHALL be sampled low at least once before the first request is accepted.

Verification
REQ-024 WAIT_CYCLES=1: load 0x005=0x1234, then i_ce=1, i_we=0, i_addr=0x005 accepted at edge N -> o_busy=1, o_ready=1 after edge N+2, o_data=0x1234; o_ready=0 after N+3.
REQ-025 Write 0x0FF<=0xBEEF, drop i_ce, then read 0x0FF -> o_data=0xBEEF; o_data unchanged (still the prior value) during the write's o_ready pulse.
REQ-026 i_ce held high for 10 cycles after one read -> exactly one o_ready pulse; i_ce low for one cycle then high -> a second pulse.
REQ-027 Write request to 0x010 of 0xAAAA, reset asserted during WAIT -> o_busy=0, no o_ready; a subsequent read of 0x010 returns its preloaded 0x0000.
REQ-028 i_ld_en=1 and i_ce=1 in the same IDLE cycle (load 0x020=0x5555, read 0x020) -> the load wins, the read is accepted next edge and returns 0x5555; i_ld_en during WAIT -> array unchanged, o_err=1.
REQ-029 WAIT_CYCLES=0: read is accepted at edge N -> o_ready after edge N+1.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the datapath ce/we/addr/data interface.
// One access per armed request, with configurable wait states and a load port.
module mem_responder #(
    parameter int AWIDTH      = 12,
    parameter int DWIDTH      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              i_clr_reg,
    input  logic              i_ce,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_ld_en,
    input  logic [AWIDTH-1:0] i_ld_addr,
    input  logic [DWIDTH-1:0] i_ld_data,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);

    state_t            r_state;
    logic              r_armed;
    logic              r_we;
    logic [2:0]        r_cnt;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_data;
    logic [DWIDTH-1:0] r_mem [2**AWIDTH];

    logic w_ld_wr;
    logic w_acc_wr;

    // Load writes only in IDLE; the captured write lands on the ACCESS edge.
    assign w_ld_wr  = (r_state == S_IDLE) && i_ld_en && !i_clr_reg;
    assign w_acc_wr = (r_state == S_ACCESS) && r_we && !i_clr_reg;

    // Storage array, deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_ld_wr) begin
            r_mem[i_ld_addr] <= i_ld_data;
        end else if (w_acc_wr) begin
            r_mem[r_addr] <= r_data;
        end
    end

    // Request FSM with registered handshake, status and read data.
    always_ff @(posedge clk or posedge i_clr_reg) begin
        if (i_clr_reg) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            o_data  <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            if (!i_ce) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!i_ld_en && i_ce && r_armed) begin
                        r_we    <= i_we;
                        r_addr  <= i_addr;
                        r_data  <= i_data;
                        r_armed <= 1'b0;
                        o_busy  <= 1'b1;
                        if (LP_WAIT != 3'd0) begin
                            r_cnt   <= LP_WAIT;
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (!i_ce || i_ld_en) begin
                        o_err <= 1'b1;
                    end
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!i_ce || i_ld_en) begin
                        o_err <= 1'b1;
                    end
                    if (!r_we) begin
                        o_data <= r_mem[r_addr];
                    end
                    o_ready <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (i_ld_en) begin
                        o_err <= 1'b1;
                    end
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
// Latency is checked against accept edge + WAIT_CYCLES + 1.
module tb_mem_responder;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int W1 = 1;

    logic          clk = 1'b0;
    logic          clr;
    logic          ce, we, ld_en;
    logic [AW-1:0] addr, ld_addr;
    logic [DW-1:0] wdata, ld_data, rdata;
    logic          rdy, busy, err;

    logic          ce0, we0, ld_en0;
    logic [AW-1:0] addr0, ld_addr0;
    logic [DW-1:0] wdata0, ld_data0, rdata0;
    logic          rdy0, busy0, err0;

    logic [DW-1:0] mdl [2**AW];
    logic [DW-1:0] mdl_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(W1)) u_dut (
        .clk(clk), .i_clr_reg(clr),
        .i_ce(ce), .i_we(we), .i_addr(addr), .i_data(wdata),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
        .o_data(rdata), .o_ready(rdy), .o_busy(busy), .o_err(err)
    );

    mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .i_clr_reg(clr),
        .i_ce(ce0), .i_we(we0), .i_addr(addr0), .i_data(wdata0),
        .i_ld_en(ld_en0), .i_ld_addr(ld_addr0), .i_ld_data(ld_data0),
        .o_data(rdata0), .o_ready(rdy0), .o_busy(busy0), .o_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en = 1'b0;
        mdl[a] = d;
    endtask

    // One complete armed access on the WAIT_CYCLES=1 instance.
    task automatic access(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        int lat;
        ce = 1'b0;
        step();
        ce = 1'b1;
        we = w;
        addr = a;
        wdata = d;
        step();
        chk("busy_acc", 32'(busy), 32'd1);
        we = 1'($urandom);
        addr = AW'($urandom);
        wdata = DW'($urandom);
        lat = 0;
        while (!rdy && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(W1 + 1));
        if (w) mdl[a] = d;
        else mdl_out = mdl[a];
        chk("rdata", 32'(rdata), 32'(mdl_out));
        ce = 1'b0;
        step();
        chk("rdy_pulse", 32'(rdy), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        int lat;
        clr = 1'b1;
        ce = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        ce0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        ld_en0 = 1'b0; ld_addr0 = '0; ld_data0 = '0;
        mdl_out = '0;
        step();
        step();
        chk("rst_data", 32'(rdata), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);

        // Request high straight out of reset must wait for a low sample.
        ce = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("unarmed", 32'(busy), 32'd0);
        end
        ce = 1'b0;

        for (int i = 0; i < 2**AW; i++) begin
            ld(AW'(i), DW'($urandom));
        end
        ld(12'h010, 16'h0000);
        ld(12'h005, 16'h1234);

        access(1'b0, 12'h005, 16'h0);
        chk("read_005", 32'(rdata), 32'h1234);

        access(1'b1, 12'h0FF, 16'hBEEF);
        chk("wr_keeps", 32'(rdata), 32'h1234);
        access(1'b0, 12'h0FF, 16'h0);
        chk("read_0ff", 32'(rdata), 32'hBEEF);

        // Held request yields one pulse; a low sample re-arms it.
        ce = 1'b0;
        step();
        ce = 1'b1; we = 1'b0; addr = 12'h005;
        step();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            pulses += int'(rdy);
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        ce = 1'b0;
        step();
        ce = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            pulses += int'(rdy);
        end
        chk("rearm_pulses", 32'(pulses), 32'd1);
        chk("rearm_data", 32'(rdata), 32'h1234);
        ce = 1'b0;
        step();

        // Reset during WAIT aborts the write.
        ce = 1'b1; we = 1'b1; addr = 12'h010; wdata = 16'hAAAA;
        step();
        chk("abort_busy1", 32'(busy), 32'd1);
        #2 clr = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", 32'(rdata), 32'd0);
        mdl_out = '0;
        step();
        clr = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            pulses += int'(rdy) + int'(busy);
        end
        chk("abort_quiet", 32'(pulses), 32'd0);
        access(1'b0, 12'h010, 16'h0);
        chk("abort_nowr", 32'(rdata), 32'h0000);

        // Load beats a concurrent request; load during WAIT is ignored.
        ce = 1'b0;
        step();
        ce = 1'b1; we = 1'b0; addr = 12'h020;
        ld_en = 1'b1; ld_addr = 12'h020; ld_data = 16'h5555;
        step();
        mdl[12'h020] = 16'h5555;
        chk("ld_wins", 32'(busy), 32'd0);
        ld_en = 1'b0;
        step();
        chk("ld_then_acc", 32'(busy), 32'd1);
        ld_en = 1'b1; ld_data = 16'h9999;
        step();
        ld_en = 1'b0;
        chk("ld_wait_err", 32'(err), 32'd1);
        step();
        chk("ld_rdy", 32'(rdy), 32'd1);
        chk("ld_rdata", 32'(rdata), 32'h5555);
        mdl_out = 16'h5555;
        ce = 1'b0;
        step();
        access(1'b0, 12'h020, 16'h0);
        chk("ld_ignored", 32'(rdata), 32'h5555);
        chk("err_sticky", 32'(err), 32'd1);
        clr = 1'b1;
        #1;
        chk("err_clr", 32'(err), 32'd0);
        mdl_out = '0;
        step();
        clr = 1'b0;

        // Dropping ce mid-access still completes it and flags an error.
        ce = 1'b0;
        step();
        ce = 1'b1; we = 1'b1; addr = 12'h040; wdata = 16'h1357;
        step();
        ce = 1'b0;
        step();
        chk("drop_err", 32'(err), 32'd1);
        step();
        chk("drop_rdy", 32'(rdy), 32'd1);
        mdl[12'h040] = 16'h1357;
        step();
        access(1'b0, 12'h040, 16'h0);
        chk("drop_wrote", 32'(rdata), 32'h1357);
        clr = 1'b1;
        #1;
        mdl_out = '0;
        step();
        clr = 1'b0;

        // Randomized traffic with interleaved loads.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld(AW'($urandom_range(0, 63)), DW'($urandom));
            end
            access(1'($urandom), AW'($urandom_range(0, 63)), DW'($urandom));
        end
        chk("rand_err", 32'(err), 32'd0);

        // Zero wait states: ready one edge after accept.
        ld_en0 = 1'b1; ld_addr0 = 12'h033; ld_data0 = 16'h4321;
        step();
        ld_en0 = 1'b0;
        ce0 = 1'b1; we0 = 1'b0; addr0 = 12'h033;
        step();
        chk("w0_busy", 32'(busy0), 32'd1);
        lat = 0;
        while (!rdy0 && lat < 20) begin
            step();
            lat++;
        end
        chk("w0_latency", 32'(lat), 32'd1);
        chk("w0_rdata", 32'(rdata0), 32'h4321);
        ce0 = 1'b0;
        step();
        chk("w0_done", 32'(rdy0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
